// File: rtl/maxpool2x2_stream_pkg.sv
// Shared activation definitions for the mini-CNN datapath: activation width and signed max helper.
// Reused by the pooling stage and the conv-input buffer.
package maxpool2x2_stream_pkg;

    localparam int unsigned ACT_W = 8;

    // Operands are sign-extended to int by the caller, so any DATA_W up to 32 works.
    function automatic int smax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_linebuf.sv
// Half-width line buffer for the 2x2 pooler: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; every entry is written in an even row before the odd row reads it.
module maxpool_linebuf #(
    parameter int unsigned DEPTH  = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max pooling over a raster-order activation stream.
// Optional frame_done output is enabled by defining MAXPOOL_FRAME_DONE_EN.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int unsigned IMG_W  = 24,
    parameter int unsigned IMG_H  = 24,
    parameter int unsigned DATA_W = ACT_W
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic              frame_done
`endif
);

    localparam int unsigned CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned DEPTH = IMG_W / 2;
    localparam int unsigned LBW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]     col, col_eff;
    logic [RW-1:0]     row, row_eff;
    logic [DATA_W-1:0] h_reg;
    logic [DATA_W-1:0] hmax, pooled, lb_rd;
    logic [LBW-1:0]    lb_idx;
    logic              lb_we, win_done, col_last, row_last;

    // clear zeroes the position before the current pixel is classified, so a
    // pixel accepted with clear=1 is treated as (0,0) of the new frame.
    always_comb begin
        col_eff  = clear ? '0 : col;
        row_eff  = clear ? '0 : row;
        col_last = (col_eff == CW'(IMG_W - 1));
        row_last = (row_eff == RW'(IMG_H - 1));
        hmax     = DATA_W'(smax(int'($signed(h_reg)), int'($signed(in_data))));
        pooled   = DATA_W'(smax(int'($signed(lb_rd)), int'($signed(hmax))));
        lb_idx   = LBW'(col_eff >> 1);
        lb_we    = in_valid && col_eff[0] && !row_eff[0];
        win_done = in_valid && col_eff[0] && row_eff[0];
    end

    maxpool_linebuf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (LBW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (hmax),
        .raddr (lb_idx),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            col       <= '0;
            row       <= '0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (!col_eff[0]) begin
                    h_reg <= in_data;
                end
                if (win_done) begin
                    out_valid <= 1'b1;
                    out_data  <= pooled;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row_eff + 1'b1;
                end else begin
                    col <= col_eff + 1'b1;
                    row <= row_eff;
                end
            end else if (clear) begin
                col <= '0;
                row <= '0;
            end
        end
    end

`ifdef MAXPOOL_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= win_done && col_last && row_last;
        end
    end
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x2 instance for directed cases and a 24x24 instance
// for random frames, both checked every cycle against a frame-array reference model.
module tb_maxpool2x2_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b;
    logic       clear_s, in_valid_s, out_valid_s;
    logic [7:0] in_data_s, out_data_s;
    logic       clear_b, in_valid_b, out_valid_b;
    logic [7:0] in_data_b, out_data_b;
`ifdef MAXPOOL_FRAME_DONE_EN
    logic       frame_done_s, frame_done_b;
`endif

    maxpool2x2_stream #(.IMG_W(4), .IMG_H(2), .DATA_W(8)) u_small (
        .clk(clk), .rst_b(rst_b), .clear(clear_s), .in_valid(in_valid_s),
        .in_data(in_data_s), .out_valid(out_valid_s), .out_data(out_data_s)
`ifdef MAXPOOL_FRAME_DONE_EN
        , .frame_done(frame_done_s)
`endif
    );

    maxpool2x2_stream #(.IMG_W(24), .IMG_H(24), .DATA_W(8)) u_big (
        .clk(clk), .rst_b(rst_b), .clear(clear_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_data(out_data_b)
`ifdef MAXPOOL_FRAME_DONE_EN
        , .frame_done(frame_done_b)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pix [24][24];
    int mr, mc;
    int last_s, last_b;
    int pulses_s, pulses_b, fd_b;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mr = 0; mc = 0; last_s = 0; last_b = 0;
    endtask

    // One clock: drive the chosen instance, then predict and check its outputs 1 time unit after the edge.
    task automatic step(input string tag, input bit big, input bit v, input int d, input bit clr);
        int w, h, ed, obs_v, obs_d;
        bit ev, efd;
        w = big ? 24 : 4;
        h = big ? 24 : 2;
        if (big) begin
            clear_b = clr; in_valid_b = v; in_data_b = 8'(d);
        end else begin
            clear_s = clr; in_valid_s = v; in_data_s = 8'(d);
        end
        @(posedge clk);
        #1;
        clear_s = 1'b0; in_valid_s = 1'b0; clear_b = 1'b0; in_valid_b = 1'b0;
        if (clr) begin mr = 0; mc = 0; end
        ev = 1'b0; efd = 1'b0;
        ed = big ? last_b : last_s;
        if (v) begin
            pix[mr][mc] = d;
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ev  = 1'b1;
                ed  = imax(imax(pix[mr-1][mc-1], pix[mr-1][mc]), imax(pix[mr][mc-1], pix[mr][mc]));
                efd = (mr == h - 1) && (mc == w - 1);
            end
            mc++;
            if (mc == w) begin
                mc = 0; mr++;
                if (mr == h) mr = 0;
            end
        end
        obs_v = big ? int'(out_valid_b) : int'(out_valid_s);
        obs_d = big ? int'($signed(out_data_b)) : int'($signed(out_data_s));
        check_int({tag, ".valid"}, obs_v, int'(ev));
        check_int({tag, ".data"}, obs_d, ed);
`ifdef MAXPOOL_FRAME_DONE_EN
        check_int({tag, ".frame_done"}, big ? int'(frame_done_b) : int'(frame_done_s), int'(efd));
`endif
        if (big) begin
            last_b = ed;
            if (obs_v == 1) pulses_b++;
            if (efd) fd_b++;
        end else begin
            last_s = ed;
            if (obs_v == 1) pulses_s++;
        end
    endtask

    int t2 [8] = '{1, 5, -3, 2, 7, -8, 0, 9};
    int t3 [8] = '{-128, -5, -128, -128, -7, -128, -128, -128};

    initial begin
        rst_b = 1'b0;
        clear_s = 1'b0; in_valid_s = 1'b0; in_data_s = '0;
        clear_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        model_reset();
        pulses_s = 0; pulses_b = 0; fd_b = 0;

        // Reset held while pixels are offered: nothing may come out.
        for (int i = 0; i < 6; i++) begin
            in_valid_s = 1'b1; in_data_s = 8'(i * 17 + 3);
            @(posedge clk);
            #1;
            check_int("reset.valid", int'(out_valid_s), 0);
            check_int("reset.data", int'(out_data_s), 0);
        end
        in_valid_s = 1'b0;
        rst_b = 1'b1;
        model_reset();

        // 4x2 directed frame, continuous then gapped.
        pulses_s = 0;
        for (int i = 0; i < 8; i++) step("cont", 1'b0, 1'b1, t2[i], 1'b0);
        check_int("cont.pulses", pulses_s, 2);
        check_int("cont.last", int'($signed(out_data_s)), 9);
        pulses_s = 0;
        for (int i = 0; i < 8; i++) begin
            step("gap", 1'b0, 1'b1, t2[i], 1'b0);
            for (int g = 0; g < 3; g++) step("gap_idle", 1'b0, 1'b0, 0, 1'b0);
        end
        check_int("gap.pulses", pulses_s, 2);

        // Signed compare: negative window and all -128.
        for (int i = 0; i < 8; i++) step("neg", 1'b0, 1'b1, t3[i], 1'b0);

        // Mid-frame async reset after 3 pixels.
        for (int i = 0; i < 3; i++) step("prerst", 1'b0, 1'b1, 100 + i, 1'b0);
        rst_b = 1'b0;
        #2;
        model_reset();
        check_int("midrst.valid", int'(out_valid_s), 0);
        check_int("midrst.data", int'(out_data_s), 0);
        rst_b = 1'b1;
        for (int i = 0; i < 8; i++) step("postrst", 1'b0, 1'b1, t2[i], 1'b0);

        // clear with in_valid on the 3rd pixel restarts the frame at that pixel.
        step("preclr", 1'b0, 1'b1, 120, 1'b0);
        step("preclr", 1'b0, 1'b1, 121, 1'b0);
        pulses_s = 0;
        step("clr_v", 1'b0, 1'b1, -20, 1'b1);
        for (int i = 1; i < 8; i++) step("postclr", 1'b0, 1'b1, t2[i] - 30, 1'b0);
        check_int("clr_v.pulses", pulses_s, 2);

        // clear without in_valid in the cycle the window pulse is visible.
        for (int i = 0; i < 6; i++) step("clr_i_pre", 1'b0, 1'b1, t2[i], 1'b0);
        step("clr_i", 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) step("clr_i_post", 1'b0, 1'b1, t3[7 - i], 1'b0);

        // Two back-to-back random 24x24 frames.
        for (int f = 0; f < 2; f++) begin
            pulses_b = 0;
            for (int i = 0; i < 576; i++)
                step("rand", 1'b1, 1'b1, int'($urandom_range(0, 255)) - 128, 1'b0);
            check_int("rand.pulses", pulses_b, 144);
        end
`ifdef MAXPOOL_FRAME_DONE_EN
        check_int("rand.frame_done_count", fd_b, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
